// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: Flappy Bird sequencer - frame tick, physics gating, flap conditioning, pillar scroll, collision, score, game FSM
// Inputs : clk, rst (async, active-low), start/flap_btn (async buttons), bird_y/gap0/gap1 (10-bit, 0 = ground)
// Outputs: tick, phys_en, flap_pulse, pipe_x0/pipe_x1, state (0 IDLE,1 PLAY,2 DEAD,3 OVER), score, hi_score, game_over
// Option : define INVINCIBLE_EN to ignore all collisions (state stays in PLAY)
module flappy_game_ctrl #(
    parameter int TICK_DIV     = 833333,
    parameter int SCREEN_W     = 640,
    parameter int PIPE_SPACING = 320,
    parameter int SCROLL       = 2,
    parameter int BIRD_X       = 160,
    parameter int PIPE_HW      = 20,
    parameter int GAP_HH       = 60,
    parameter int DEAD_TICKS   = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       flap_btn,
    input  logic [9:0] bird_y,
    input  logic [9:0] gap0,
    input  logic [9:0] gap1,
    output logic       tick,
    output logic       phys_en,
    output logic       flap_pulse,
    output logic [9:0] pipe_x0,
    output logic [9:0] pipe_x1,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [7:0] hi_score,
    output logic       game_over
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = DEAD_TICKS > 1 ? $clog2(DEAD_TICKS) : 1;
`ifdef INVINCIBLE_EN
    localparam logic INVINCIBLE = 1'b1;
`else
    localparam logic INVINCIBLE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PLAY, DEAD, OVER} state_t;
    state_t st, st_nx;

    logic [CW-1:0] cnt;
    logic [DW-1:0] dead_cnt;
    logic [2:0]    start_s, flap_s;
    logic          start_edge, flap_edge, pre_tick, flap_pend, hit, cross0, cross1;
    logic [9:0]    nx0, nx1;
    logic [8:0]    sum;

    function automatic logic pipe_hit(input logic [9:0] x, input logic [9:0] g, input logic [9:0] y);
        logic signed [10:0] ys, lo, hi_v;
        ys   = $signed({1'b0, y});
        lo   = $signed({1'b0, g}) - $signed(11'(GAP_HH));
        hi_v = $signed({1'b0, g}) + $signed(11'(GAP_HH));
        return x >= 10'(BIRD_X - PIPE_HW) && x <= 10'(BIRD_X + PIPE_HW) && (ys < lo || ys > hi_v);
    endfunction

    // stages [0],[1] synchronise; [2] holds the previous synchronised level
    assign start_edge = start_s[1] & ~start_s[2];
    assign flap_edge  = flap_s[1] & ~flap_s[2];
    assign tick       = cnt == CW'(TICK_DIV - 1);
    assign pre_tick   = cnt == CW'(TICK_DIV - 2);
    assign phys_en    = tick && st == PLAY;
    assign state      = st;
    assign hit        = !INVINCIBLE && (bird_y == '0 || pipe_hit(pipe_x0, gap0, bird_y) || pipe_hit(pipe_x1, gap1, bird_y));
    assign nx0        = pipe_x0 < 10'(SCROLL) ? 10'(SCREEN_W) : pipe_x0 - 10'(SCROLL);
    assign nx1        = pipe_x1 < 10'(SCROLL) ? 10'(SCREEN_W) : pipe_x1 - 10'(SCROLL);
    assign cross0     = pipe_x0 >= 10'(BIRD_X) && nx0 < 10'(BIRD_X);
    assign cross1     = pipe_x1 >= 10'(BIRD_X) && nx1 < 10'(BIRD_X);
    assign sum        = {1'b0, score} + 9'(cross0) + 9'(cross1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) st <= IDLE;
        else      st <= st_nx;

    always_comb begin
        st_nx = st;
        if (start_edge && (st == IDLE || st == OVER))                      st_nx = PLAY;
        else if (tick && st == PLAY && hit)                                st_nx = DEAD;
        else if (tick && st == DEAD && dead_cnt == DW'(DEAD_TICKS - 1))    st_nx = OVER;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            dead_cnt   <= '0;
            start_s    <= '0;
            flap_s     <= '0;
            flap_pend  <= 1'b0;
            flap_pulse <= 1'b0;
            pipe_x0    <= 10'(SCREEN_W);
            pipe_x1    <= 10'(SCREEN_W + PIPE_SPACING);
            score      <= '0;
            hi_score   <= '0;
            game_over  <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            start_s    <= {start_s[1:0], start};
            flap_s     <= {flap_s[1:0], flap_btn};
            // an edge seen during the tick cycle belongs to the following frame
            flap_pend  <= st != PLAY || st_nx != PLAY ? 1'b0 : tick ? flap_edge : flap_pend | flap_edge;
            // decided one cycle early so the registered pulse lines up with phys_en
            flap_pulse <= pre_tick && st == PLAY && (flap_pend || flap_edge);
            game_over  <= st_nx == DEAD || st_nx == OVER;
            dead_cnt   <= st != DEAD ? '0 : tick ? dead_cnt + 1'b1 : dead_cnt;
            if (st != PLAY && st_nx == PLAY) begin
                pipe_x0 <= 10'(SCREEN_W);
                pipe_x1 <= 10'(SCREEN_W + PIPE_SPACING);
                score   <= '0;
            end else if (st == PLAY && tick && !hit) begin
                pipe_x0 <= nx0;
                pipe_x1 <= nx1;
                score   <= sum[8] ? 8'hff : sum[7:0];
            end
            if (st == PLAY && st_nx == DEAD && score > hi_score) hi_score <= score;
        end
    end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed bench with a frame-level reference model for flappy_game_ctrl
module tb_flappy_game_ctrl;
    localparam int TD = 4, SC = 2, DT = 3, SW = 640, SP = 320, BX = 160, HW = 20, GH = 60;
`ifdef INVINCIBLE_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, flap_btn = 1'b0;
    logic [9:0] bird_y = 10'd240, gap0 = 10'd240, gap1 = 10'd240;
    logic tick, phys_en, flap_pulse, game_over;
    logic [9:0] pipe_x0, pipe_x1;
    logic [1:0] state;
    logic [7:0] score, hi_score;

    int checks = 0, failures = 0;

    flappy_game_ctrl #(.TICK_DIV(TD), .SCROLL(SC), .DEAD_TICKS(DT)) dut (
        .clk(clk), .rst(rst), .start(start), .flap_btn(flap_btn),
        .bird_y(bird_y), .gap0(gap0), .gap1(gap1),
        .tick(tick), .phys_en(phys_en), .flap_pulse(flap_pulse),
        .pipe_x0(pipe_x0), .pipe_x1(pipe_x1), .state(state),
        .score(score), .hi_score(hi_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // frame-level model: button history, tick phase, game state, pillars, score
    int m_st, m_x0, m_x1, m_sc, m_hi, m_dc, m_tc;
    bit m_pend;
    bit sh[3], fh[3];

    function automatic bit phit(input int x, input int g, input int y);
        return x >= BX - HW && x <= BX + HW && (y < g - GH || y > g + GH);
    endfunction

    task automatic model_step();
        bit se, fe, tk, h;
        int inc;
        se = sh[1] && !sh[2];
        fe = fh[1] && !fh[2];
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start;
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = flap_btn;
        tk = m_tc == TD - 1;
        m_tc = (m_tc + 1) % TD;
        h = !INV && (bird_y == 0 || phit(m_x0, gap0, bird_y) || phit(m_x1, gap1, bird_y));
        case (m_st)
            0, 3: if (se) begin m_st = 1; m_x0 = SW; m_x1 = SW + SP; m_sc = 0; m_pend = 0; end
            1: begin
                if (tk && h) begin
                    m_st = 2; m_dc = 0; m_pend = 0;
                    if (m_sc > m_hi) m_hi = m_sc;
                end else if (tk) begin
                    inc = 0;
                    if (m_x0 >= BX && m_x0 - SC < BX) inc++;
                    if (m_x1 >= BX && m_x1 - SC < BX) inc++;
                    m_sc = m_sc + inc > 255 ? 255 : m_sc + inc;
                    m_x0 = m_x0 < SC ? SW : m_x0 - SC;
                    m_x1 = m_x1 < SC ? SW : m_x1 - SC;
                    m_pend = fe;
                end else m_pend = m_pend | fe;
            end
            2: if (tk) begin m_dc++; if (m_dc == DT) m_st = 3; end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0; m_x0 = SW; m_x1 = SW + SP; m_sc = 0; m_hi = 0; m_dc = 0; m_tc = 0; m_pend = 0;
            sh = '{0, 0, 0}; fh = '{0, 0, 0};
        end else model_step();
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("tick", tick, m_tc == TD - 1);
            chk("phys_en", phys_en, m_tc == TD - 1 && m_st == 1);
            chk("flap_pulse", flap_pulse, m_tc == TD - 1 && m_st == 1 && m_pend);
            chk("pipe_x0", pipe_x0, m_x0);
            chk("pipe_x1", pipe_x1, m_x1);
            chk("state", state, m_st);
            chk("score", score, m_sc);
            chk("hi_score", hi_score, m_hi);
            chk("game_over", game_over, m_st == 2 || m_st == 3);
        end
    end

    task automatic next_frame();
        bit seen = 0;
        for (int i = 0; i < 2 * TD + 2 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        if (!seen) chk("frame_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n, p, pulses, misal;
        bit found;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // idle: free-running tick, no physics, pillars parked
        n = 0; p = 0;
        repeat (20) begin @(negedge clk); n += tick; p += phys_en; end
        chk("s1_ticks", n, 5);
        chk("s1_phys", p, 0);
        chk("s1_state", state, 0);
        chk("s1_x0", pipe_x0, 640);
        chk("s1_x1", pipe_x1, 960);
        // start, five physics steps
        press_start();
        p = 0;
        for (int i = 0; i < 60 && p < 5; i++) begin @(negedge clk); p += phys_en; end
        @(negedge clk);
        chk("s2_phys", p, 5);
        chk("s2_state", state, 1);
        chk("s2_x0", pipe_x0, 630);
        chk("s2_x1", pipe_x1, 950);
        chk("s2_score", score, 0);
        // two flap edges inside one frame collapse into one pulse
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); found = tick; end
        repeat (2) @(negedge clk);
        flap_btn = 1'b1; @(negedge clk);
        flap_btn = 1'b0; @(negedge clk);
        flap_btn = 1'b1; @(negedge clk);
        flap_btn = 1'b0;
        pulses = 0; misal = 0;
        repeat (12) begin @(negedge clk); pulses += flap_pulse; misal += flap_pulse && !phys_en; end
        chk("s3_pulses", pulses, 1);
        chk("s3_misaligned", misal, 0);
        // scroll pillar 0 up to the bird column
        found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin @(negedge clk); found = pipe_x0 == 162; end
        chk("s4_reach", pipe_x0, 162);
        chk("s4_score0", score, 0);
        next_frame();
        chk("s4_x0_160", pipe_x0, 160);
        chk("s4_score_160", score, 0);
        next_frame();
        chk("s4_x0_158", pipe_x0, 158);
        chk("s4_score_158", score, 1);
        // bird below the gap inside the column: dead, frozen
        bird_y = 10'd100;
        next_frame();
        chk("s5_state", state, 2);
        chk("s5_game_over", game_over, 1);
        chk("s5_hi", hi_score, 1);
        chk("s5_x0", pipe_x0, 158);
        chk("s5_score", score, 1);
        press_start();
        next_frame();
        chk("s5_dead1", state, 2);
        next_frame();
        chk("s5_dead2", state, 2);
        next_frame();
        chk("s5_over", state, 3);
        chk("s5_x0_frozen", pipe_x0, 158);
        bird_y = 10'd240;
        press_start();
        repeat (3) @(negedge clk);
        chk("s5_restart", state, 1);
        chk("s5_restart_score", score, 0);
        chk("s5_hi_kept", hi_score, 1);
        // asynchronous reset mid-play
        next_frame();
        next_frame();
        #2 rst = 1'b0;
        #1;
        chk("s6_state", state, 0);
        chk("s6_x0", pipe_x0, 640);
        chk("s6_x1", pipe_x1, 960);
        chk("s6_score", score, 0);
        chk("s6_hi", hi_score, 0);
        chk("s6_go", game_over, 0);
        chk("s6_tick", tick, 0);
        chk("s6_phys", phys_en, 0);
        chk("s6_flap", flap_pulse, 0);
        @(negedge clk);
        rst = 1'b1;
        press_start();
        repeat (4) @(negedge clk);
        chk("s6_play", state, 1);
        bird_y = 10'd0;
`ifdef INVINCIBLE_EN
        for (int i = 0; i < 50; i++) begin
            next_frame();
            chk("s6_invincible", state, 1);
        end
`else
        next_frame();
        chk("s6_ground", state, 2);
        chk("s6_ground_go", game_over, 1);
        repeat (3) next_frame();
        chk("s6_ground_over", state, 3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
